// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the fetch/data memory arbiter
//
// Purpose: owner encoding for the read-return pipeline register and the
//          width of the fetch starvation counter.
// Contents:
//    CNT_W   - starvation counter width (holds limits 1..15)
//    owner_t - which requester owns the read data returning next cycle

package mem_arb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_t;

endpackage

// File: rtl/mem_arb_starve.sv
// rtl/mem_arb_starve.sv - saturating counter of consecutive fetch denials
//
// Purpose: counts cycles in which fetch asked for the RAM but lost; reports
//          when the count has reached LIMIT so the arbiter can force a fetch.
// Ports:
//    clk      in   rising-edge clock
//    rst      in   asynchronous active-high reset, clears the count
//    inc      in   fetch requested and was denied this cycle
//    clr      in   fetch was granted or is not requesting (wins over inc)
//    at_limit out  count equals LIMIT

module mem_arb_starve
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != LIMIT_C)) begin
         // saturate at the limit rather than wrapping back to zero
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - fetch/data arbiter in front of a single-port synchronous RAM
//
// Purpose: grants one of two requesters (instruction fetch, data) the RAM each
//          cycle, combinationally. Data wins by default. When built with
//          MEM_ARB_STARVE_EN, fetch is forced through after STARVE_LIMIT
//          consecutive denials. Read data returns one cycle after the grant on
//          the granted side only; the other side's rdata is held at zero.
// Ports:
//    clk, rst                         clock, asynchronous active-high reset
//    if_req, if_addr                  fetch read request
//    if_gnt, if_valid, if_rdata       fetch grant, read-return strobe and data
//    dm_req, dm_we, dm_addr, dm_wdata data request (read or write)
//    dm_gnt, dm_valid, dm_rdata       data grant, read-return strobe and data
//    ram_addr, ram_we, ram_wdata      RAM command for the granted requester
//    ram_rdata                        RAM read data (1-cycle latency)
//    stall                            fetch requesting but not granted
// Build option: MEM_ARB_STARVE_EN enables the starvation counter and override.

module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 9,
   parameter int WORD_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_valid,
   output logic [WORD_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [WORD_WIDTH-1:0] dm_wdata,
   output logic                  dm_gnt,
   output logic                  dm_valid,
   output logic [WORD_WIDTH-1:0] dm_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [WORD_WIDTH-1:0] ram_wdata,
   input  logic [WORD_WIDTH-1:0] ram_rdata,
   output logic                  stall
);

   owner_t owner_q;
   owner_t owner_d;
   logic   force_if;

`ifdef MEM_ARB_STARVE_EN
   logic at_limit;

   mem_arb_starve #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .rst      (rst),
      .inc      (stall),
      .clr      (~if_req | if_gnt),
      .at_limit (at_limit)
   );

   assign force_if = at_limit & if_req;
`else
   // No counter: strict data priority. A zero limit would degenerate to
   // fetch-always-wins; any legal limit (1..15) leaves this tied off.
   assign force_if = (STARVE_LIMIT == 0) & if_req;
`endif

   always_comb begin
      // grants are suppressed while reset is held so nothing reaches the RAM
      dm_gnt    = ~rst & dm_req & ~force_if;
      if_gnt    = ~rst & if_req & ~dm_gnt;
      stall     = ~rst & if_req & ~if_gnt;

      ram_addr  = if_addr;
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (dm_gnt) begin
         ram_addr  = dm_addr;
         ram_we    = dm_we;
         ram_wdata = dm_wdata;
      end

      // only reads need a return path; writes leave the owner empty
      owner_d = OWN_NONE;
      if (dm_gnt && !dm_we) begin
         owner_d = OWN_DM;
      end else if (if_gnt) begin
         owner_d = OWN_IF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   assign if_valid = (owner_q == OWN_IF);
   assign dm_valid = (owner_q == OWN_DM);
   assign if_rdata = if_valid ? ram_rdata : '0;
   assign dm_rdata = dm_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - randomized self-checking bench for mem_arb

module tb_mem_arb;

   localparam int AW  = 9;
   localparam int WW  = 32;
   localparam int LIM = 4;
`ifdef MEM_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt, if_valid;
   logic [WW-1:0] if_rdata;
   logic          dm_req, dm_we;
   logic [AW-1:0] dm_addr;
   logic [WW-1:0] dm_wdata;
   logic          dm_gnt, dm_valid;
   logic [WW-1:0] dm_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [WW-1:0] ram_wdata;
   logic [WW-1:0] ram_rdata;
   logic          stall;

   mem_arb #(
      .ADDR_WIDTH   (AW),
      .WORD_WIDTH   (WW),
      .STARVE_LIMIT (LIM)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_valid  (if_valid),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_gnt    (dm_gnt),
      .dm_valid  (dm_valid),
      .dm_rdata  (dm_rdata),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .stall     (stall)
   );

   always #5 clk = ~clk;

   // environment RAM: single port, 1-cycle synchronous read
   logic [WW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // reference model state
   logic [WW-1:0] ref_mem [0:(1<<AW)-1];
   int            den;
   bit            pend_if, pend_dm;
   logic [WW-1:0] pend_data;
   int            errors = 0;
   int            checks = 0;
   int            if_grants;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_return();
      chk("if_valid", 32'(if_valid), 32'(pend_if));
      chk("if_rdata", if_rdata, pend_if ? pend_data : 32'h0);
      chk("dm_valid", 32'(dm_valid), 32'(pend_dm));
      chk("dm_rdata", dm_rdata, pend_dm ? pend_data : 32'h0);
   endtask

   task automatic step(input bit ireq, input logic [AW-1:0] ia, input bit dreq, input bit dwe,
                       input logic [AW-1:0] da, input logic [WW-1:0] dwd);
      bit e_dm, e_if;
      @(negedge clk);
      rst = 1'b0; if_req = ireq; if_addr = ia;
      dm_req = dreq; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
      #1;
      e_dm = dreq && !(STARVE && ireq && den >= LIM);
      e_if = ireq && !e_dm;
      chk("if_gnt", 32'(if_gnt), 32'(e_if));
      chk("dm_gnt", 32'(dm_gnt), 32'(e_dm));
      chk("stall", 32'(stall), 32'(ireq && !e_if));
      chk("ram_we", 32'(ram_we), 32'(e_dm && dwe));
      chk("ram_addr", 32'(ram_addr), 32'(e_dm ? da : ia));
      if (e_dm && dwe) chk("ram_wdata", ram_wdata, dwd);
      check_return();
      pend_if   = e_if;
      pend_dm   = e_dm && !dwe;
      pend_data = e_if ? ref_mem[ia] : ref_mem[da];
      if (e_dm && dwe) ref_mem[da] = dwd;
      den = (ireq && !e_if) ? ((den < LIM) ? den + 1 : LIM) : 0;
      if (if_gnt) if_grants++;
   endtask

   task automatic rst_step(input bit ireq, input bit dreq);
      @(negedge clk);
      rst = 1'b1; if_req = ireq; dm_req = dreq; dm_we = 1'b0;
      #1;
      chk("rst_if_gnt", 32'(if_gnt), 32'h0);
      chk("rst_dm_gnt", 32'(dm_gnt), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_ram_we", 32'(ram_we), 32'h0);
      chk("rst_if_valid", 32'(if_valid), 32'h0);
      chk("rst_dm_valid", 32'(dm_valid), 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_dm_rdata", dm_rdata, 32'h0);
      pend_if = 1'b0; pend_dm = 1'b0; den = 0;
   endtask

   initial begin
      logic [WW-1:0] v;
      rst = 1'b1; if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      for (int i = 0; i < (1<<AW); i++) begin
         v = $urandom;
         mem[i] = v;
         ref_mem[i] = v;
      end
      mem[5] = 32'hDEADBEEF;
      ref_mem[5] = 32'hDEADBEEF;
      den = 0; pend_if = 1'b0; pend_dm = 1'b0; pend_data = '0; if_grants = 0;

      rst_step(1'b1, 1'b1);

      // lone fetch of address 5, first cycle out of reset
      step(1, 5, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("fetch5_data", if_rdata, 32'hDEADBEEF);

      // data write then read-back of address 7
      step(0, 0, 1, 1, 7, 32'h12345678);
      chk("wr7_no_valid_next", 32'(dm_valid), 32'h0);
      step(0, 0, 1, 0, 7, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("rd7_data", dm_rdata, 32'h12345678);

      // both requesters held high
      if_grants = 0;
      for (int i = 0; i < 10; i++) step(1, 3, 1, 0, 4, 0);
      chk("held_if_grants", 32'(if_grants), STARVE ? 32'd2 : 32'd0);
      step(0, 0, 0, 0, 0, 0);

      // reset the cycle after a fetch grant
      step(1, 5, 0, 0, 0, 0);
      rst_step(1'b1, 1'b1);
      rst_step(1'b1, 1'b0);
      step(1, 9, 0, 0, 0, 0);
      chk("post_rst_gnt", 32'(if_gnt), 32'h1);
      step(0, 0, 0, 0, 0, 0);

      // randomized traffic over a small address window
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else begin
            step(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 AW'($urandom_range(0, 15)), $urandom);
         end
      end
      step(0, 0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
